// File: rtl/nmi_clint_pkg.sv
// Shared register offsets and helpers for the nmi_clint machine-timer / software-interrupt block.
package nmi_clint_pkg;

  localparam logic [5:0] MSIP_OFS        = 6'h00;
  localparam logic [5:0] MTIMECMP_LO_OFS = 6'h08;
  localparam logic [5:0] MTIMECMP_HI_OFS = 6'h0C;
  localparam logic [5:0] MTIME_LO_OFS    = 6'h10;
  localparam logic [5:0] MTIME_HI_OFS    = 6'h14;
  localparam logic [5:0] PRESCALE_OFS    = 6'h18;
  localparam logic [5:0] CTRL_OFS        = 6'h1C;

  // Byte-lane merge of a bus write into the current register value.
  function automatic logic [31:0] merge32(input logic [31:0] old_val,
                                          input logic [31:0] wdata,
                                          input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/nmi_clint_timer.sv
// Prescaled 64-bit mtime counter with per-word write ports and registered mtime >= mtimecmp flag.
module nmi_clint_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [15:0] prescale_i,
  input  logic        cnt_clr_i,
  input  logic        lo_we_i,
  input  logic        hi_we_i,
  input  logic [31:0] lo_wdata_i,
  input  logic [31:0] hi_wdata_i,
  input  logic [63:0] mtimecmp_i,
  output logic [63:0] mtime_o,
  output logic        timer_irq_o
);

  logic [15:0] cnt_q;
  logic [63:0] mtime_q;
  logic        irq_q;
  logic        tick;

  // A prescale write restarts the period, so no tick is taken on that edge.
  assign tick = en_i && !cnt_clr_i && (cnt_q == prescale_i);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == prescale_i) ? 16'd0 : cnt_q + 16'd1;
    end
  end

  // Software writes beat the tick: the increment is dropped on a write edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q <= '0;
    end else if (lo_we_i || hi_we_i) begin
      if (lo_we_i) mtime_q[31:0]  <= lo_wdata_i;
      if (hi_we_i) mtime_q[63:32] <= hi_wdata_i;
    end else if (tick) begin
      mtime_q <= mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_q <= 1'b0;
    else       irq_q <= (mtime_q >= mtimecmp_i);
  end

  assign mtime_o     = mtime_q;
  assign timer_irq_o = irq_q;

endmodule

// File: rtl/nmi_clint.sv
// CLINT-style timer and software-interrupt slave on the NMI bus; drives the core's soft and timer irqs.
module nmi_clint
  import nmi_clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
  parameter logic [15:0] PRESCALE_RST = 16'd0,
  parameter logic        EN_RST       = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        nmi_valid_i,
  output logic        nmi_ready_o,
  input  logic [31:0] nmi_addr_i,
  input  logic [31:0] nmi_wdata_i,
  input  logic [3:0]  nmi_wstrb_i,
  output logic [31:0] nmi_rdata_o,
  output logic        soft_irq_o,
  output logic        timer_irq_o
);

  logic        ready_q;
  logic [31:0] rdata_q;
  logic        msip_q;
  logic        soft_q;
  logic        en_q;
  logic [15:0] prescale_q;
  logic [63:0] mtimecmp_q;
  logic [31:0] hi_shadow_q;
  logic [63:0] mtime;

  logic        hit;
  logic        accept;
  logic        is_wr;
  logic        wr_en;
  logic        rd_en;
  logic [5:0]  ofs;
  logic [31:0] cur_word;
  logic [31:0] rd_word;
  logic [31:0] wr_word;

  assign ofs    = nmi_addr_i[5:0];
  assign hit    = (nmi_addr_i[31:6] == BASE_ADDR[31:6]);
  assign accept = nmi_valid_i && hit && !ready_q;
  assign is_wr  = |nmi_wstrb_i;
  assign wr_en  = accept && is_wr;
  assign rd_en  = accept && !is_wr;

  // cur_word is the live register value (write-merge base); reads of MTIME_HI see the shadow instead.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    cur_word = '0;
    case (ofs)
      MSIP_OFS:        cur_word = {31'd0, msip_q};
      MTIMECMP_LO_OFS: cur_word = mtimecmp_q[31:0];
      MTIMECMP_HI_OFS: cur_word = mtimecmp_q[63:32];
      MTIME_LO_OFS:    cur_word = mtime[31:0];
      MTIME_HI_OFS:    cur_word = mtime[63:32];
      PRESCALE_OFS:    cur_word = {16'd0, prescale_q};
      CTRL_OFS:        cur_word = {31'd0, en_q};
      default:         cur_word = '0;
    endcase
    rd_word = (ofs == MTIME_HI_OFS) ? hi_shadow_q : cur_word;
  end

  assign wr_word = merge32(cur_word, nmi_wdata_i, nmi_wstrb_i);

  // Single-outstanding handshake: ready is a one-cycle pulse, so valid is ignored while it is high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      hi_shadow_q <= '0;
    end else begin
      ready_q <= accept;
      rdata_q <= rd_en ? rd_word : 32'd0;
      if (rd_en && ofs == MTIME_LO_OFS) hi_shadow_q <= mtime[63:32];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      msip_q     <= 1'b0;
      soft_q     <= 1'b0;
      en_q       <= EN_RST;
      prescale_q <= PRESCALE_RST;
      mtimecmp_q <= '1;
    end else begin
      soft_q <= msip_q;
      if (wr_en) begin
        case (ofs)
          MSIP_OFS:        msip_q            <= wr_word[0];
          MTIMECMP_LO_OFS: mtimecmp_q[31:0]  <= wr_word;
          MTIMECMP_HI_OFS: mtimecmp_q[63:32] <= wr_word;
          PRESCALE_OFS:    prescale_q        <= wr_word[15:0];
          CTRL_OFS:        en_q              <= wr_word[0];
          default: ;
        endcase
      end
    end
  end

  nmi_clint_timer u_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_q),
    .prescale_i  (prescale_q),
    .cnt_clr_i   (wr_en && ofs == PRESCALE_OFS),
    .lo_we_i     (wr_en && ofs == MTIME_LO_OFS),
    .hi_we_i     (wr_en && ofs == MTIME_HI_OFS),
    .lo_wdata_i  (wr_word),
    .hi_wdata_i  (wr_word),
    .mtimecmp_i  (mtimecmp_q),
    .mtime_o     (mtime),
    .timer_irq_o (timer_irq_o)
  );

  assign nmi_ready_o = ready_q;
  assign nmi_rdata_o = rdata_q;
  assign soft_irq_o  = soft_q;

endmodule

// File: doc/nmi_clint.md
Name: nmi_clint

Overview:
- Machine-timer and software-interrupt block for the user core tile, modelled on the RISC-V CLINT.
- Sits as a slave on the core's NMI bus. Drives the soft_irq (irq_i[0]) and timer_irq (irq_i[1]) inputs of the user core.
- Provides a 64-bit mtime with a programmable prescaler, a 64-bit mtimecmp, and an msip bit.
- All registers are 32-bit and accessed through a single-outstanding valid/ready NMI slave port.

Parameters:
- BASE_ADDR, 32'h0200_0000, base of the 64-byte register window; the block decodes addr[31:6] == BASE_ADDR[31:6].
- PRESCALE_RST, 16'd0, reset value of PRESCALE; mtime ticks every PRESCALE+1 enabled cycles.
- EN_RST, 1'b1, reset value of CTRL.en.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous, active-high reset
- nmi_valid_i  in  1  request valid; held stable until ready
- nmi_ready_o  out  1  one-cycle acknowledge
- nmi_addr_i  in  32  byte address
- nmi_wdata_i  in  32  write data
- nmi_wstrb_i  in  4  byte strobes; 0 = read
- nmi_rdata_o  out  32  read data, valid while nmi_ready_o=1
- soft_irq_o  out  1  msip[0], to core soft_irq
- timer_irq_o  out  1  mtime >= mtimecmp, to core timer_irq

Behaviour:
- Reset (async assert, sync release). Reset values:
  - nmi_ready_o=0, nmi_rdata_o=0, soft_irq_o=0, timer_irq_o=0
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0
  - PRESCALE=PRESCALE_RST, CTRL.en=EN_RST, prescale counter=0, hi shadow=0
- Register map (offset, access):
  - 0x00 MSIP: bit0 RW, other bits read 0
  - 0x08 MTIMECMP_LO, RW
  - 0x0C MTIMECMP_HI, RW
  - 0x10 MTIME_LO, RW
  - 0x14 MTIME_HI, RW
  - 0x18 PRESCALE: [15:0] RW
  - 0x1C CTRL: bit0 en RW
  - All other offsets read 0; writes to them are ignored.
- Handshake:
  - Valid is sampled when ready=0. Ready pulses high exactly one cycle later (latency 1), with rdata registered.
  - Ready deasserts the following cycle. Back-to-back requests therefore complete every 2 cycles.
  - Requests outside the window are not acknowledged; the bus fabric handles them.
  - Deasserting valid before ready is illegal. Behaviour is undefined, but the block must not hang.
- Writes: bytes are merged per nmi_wstrb_i and take effect at the edge where ready is driven high.
- Atomic 64-bit read:
  - A read of MTIME_LO captures mtime[63:32] into the hi shadow in the same cycle it samples mtime[31:0].
  - A read of MTIME_HI returns the shadow.
  - Software must read LO before HI.
- Timer:
  - While en=1, the prescale counter increments each cycle.
  - When counter == PRESCALE: counter <= 0 and mtime <= mtime+1. The 64-bit addition wraps from all-ones to 0.
  - en=0 freezes both the counter and mtime.
  - A write to PRESCALE clears the counter.
- Simultaneous tick and software write to MTIME_LO/HI: the write wins for the written bytes; the tick is dropped for that cycle.
- Interrupts:
  - timer_irq_o is registered: it equals the (mtime >= mtimecmp) result of the previous cycle, unsigned 64-bit compare. It is level and stays high until mtimecmp is raised or mtime wraps.
  - soft_irq_o is registered from msip[0]; it rises 1 cycle after the write acknowledge edge.
- Reset mid-transaction: ready and rdata are cleared immediately. The outstanding request is dropped and the master must reissue it.

Decomposition:
- Package nmi_clint_pkg holds:
  - offset localparams: MSIP_OFS, MTIMECMP_LO_OFS, MTIMECMP_HI_OFS, MTIME_LO_OFS, MTIME_HI_OFS, PRESCALE_OFS, CTRL_OFS
  - a strobe-merge function: merge32(old, wdata, wstrb)
- One sub-module, nmi_clint_timer, contains:
  - the prescaler, the 64-bit mtime counter with per-word write ports and the tick/write priority, and the registered compare output
- The top level owns the NMI decode, the hi shadow, msip, and mtimecmp.

Test Plan:
- Reset, then read every offset:
  - MTIMECMP_LO/HI read FFFF_FFFF
  - all others read 0, except CTRL=1 and PRESCALE=PRESCALE_RST
  - ready pulses exactly 1 cycle after each valid
  - both irq outputs are 0
- PRESCALE=3, MTIMECMP={0,10}, MTIME=0, en=1 -> mtime increments every 4 cycles; timer_irq_o rises 1 cycle after mtime reaches 10; writing MTIMECMP_LO=100 clears it 1 cycle later.
- MTIME={32'h0,32'hFFFF_FFFF}, PRESCALE=0 -> the next tick gives MTIME_HI=1, LO=0. Read LO then HI: the returned pair is consistent even though mtime continues to tick between the two reads.
- Write MSIP with wdata=1, wstrb=4'b0001 -> soft_irq_o=1. Write wstrb=4'b0010, wdata=0 -> no change. Write wstrb=4'b0001, wdata=0 -> soft_irq_o=0.
- With PRESCALE=0, write MTIME_LO=0x1234 on a tick cycle -> readback is 0x1234 plus the ticks since the write, not 0x1235 plus extra. Then en=0 -> mtime frozen over 50 cycles.
- Assert rst_i while a read is pending -> ready stays 0, all registers return to reset values, and the next request completes normally.
